// File: rtl/angle_spi_sampler.sv
// Round-robin SPI (mode 3) poller for N A1339-class angle sensors on a shared bus with per-sensor selects.
// Optional build macro ANGLE_SPI_PARITY_CHECK_EN: odd-parity check on rx[12] plus parity_fail_count_o.
module angle_spi_sampler #(
  parameter int          NUMBER_OF_SENSORS = 6,
  parameter int          CLOCK_SPEED_HZ    = 50_000_000,
  parameter int          SCK_HZ            = 1_000_000,
  parameter int          GAP_CYCLES        = 50,
  parameter logic [15:0] READ_CMD          = 16'h2000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            clear_errors,
  input  logic                            miso,
  output logic                            mosi,
  output logic                            sck,
  output logic [NUMBER_OF_SENSORS-1:0]    ss_n,
  output logic [12*NUMBER_OF_SENSORS-1:0] angle_o,
  output logic [NUMBER_OF_SENSORS-1:0]    angle_valid_o,
  output logic [NUMBER_OF_SENSORS-1:0]    error_o,
  output logic                            busy_o
`ifdef ANGLE_SPI_PARITY_CHECK_EN
  ,
  output logic [15:0]                     parity_fail_count_o
`endif
);

  localparam int HALF    = CLOCK_SPEED_HZ / (2 * SCK_HZ);
  localparam int CNT_MAX = (HALF > GAP_CYCLES) ? HALF : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1;

  typedef enum logic [2:0] {IDLE, SELECT, SHIFT, DESELECT, RESULT, GAP} state_t;

  state_t                       state;
  logic [CW-1:0]                cnt;
  logic [3:0]                   bit_cnt;
  logic [IW-1:0]                idx;
  logic [NUMBER_OF_SENSORS-1:0] first_frame;
  logic [15:0]                  rx;
  logic                         half_done;
  logic                         sample;
  logic                         frame_bad;

  assign half_done = (cnt == CW'(HALF - 1));
  // miso is captured on the same clock that drives sck high
  assign sample    = (state == SHIFT) && half_done && !sck;

`ifdef ANGLE_SPI_PARITY_CHECK_EN
  logic parity_fail;
  assign parity_fail = ~(^rx);
  assign frame_bad   = rx[15] | parity_fail;
`else
  assign frame_bad   = rx[15];
`endif

  // Receive shift register is pure datapath; a dropped frame never reaches RESULT.
  always_ff @(posedge clock) begin
    if (sample) rx <= {rx[14:0], miso};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      idx           <= '0;
      first_frame   <= '1;
      ss_n          <= '1;
      sck           <= 1'b1;
      mosi          <= 1'b0;
      angle_o       <= '0;
      angle_valid_o <= '0;
      error_o       <= '0;
      busy_o        <= 1'b0;
`ifdef ANGLE_SPI_PARITY_CHECK_EN
      parity_fail_count_o <= '0;
`endif
    end else begin
      angle_valid_o <= '0;
      // A set in RESULT below overrides this clear for the same bit.
      if (clear_errors) error_o <= '0;

      case (state)
        IDLE: begin
          if (enable) begin
            state     <= SELECT;
            ss_n[idx] <= 1'b0;
            mosi      <= READ_CMD[15];
            cnt       <= '0;
            busy_o    <= 1'b1;
          end
        end

        SELECT: begin
          if (half_done) begin
            state   <= SHIFT;
            cnt     <= '0;
            sck     <= 1'b0;
            bit_cnt <= 4'd15;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (half_done) begin
            cnt <= '0;
            if (!sck) begin
              sck <= 1'b1;
            end else if (bit_cnt == 4'd0) begin
              state <= DESELECT;
            end else begin
              sck     <= 1'b0;
              bit_cnt <= bit_cnt - 4'd1;
              mosi    <= READ_CMD[bit_cnt - 4'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DESELECT: begin
          if (half_done) begin
            state <= RESULT;
            cnt   <= '0;
            ss_n  <= '1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESULT: begin
          // The first response after reset answers a command we never sent.
          if (first_frame[idx]) begin
            first_frame[idx] <= 1'b0;
          end else begin
`ifdef ANGLE_SPI_PARITY_CHECK_EN
            if (parity_fail && parity_fail_count_o != 16'hFFFF)
              parity_fail_count_o <= parity_fail_count_o + 16'd1;
`endif
            if (frame_bad) begin
              error_o[idx] <= 1'b1;
            end else begin
              angle_o[12*idx +: 12] <= rx[11:0];
              angle_valid_o[idx]    <= 1'b1;
            end
          end
          idx   <= (idx == IW'(NUMBER_OF_SENSORS - 1)) ? '0 : idx + 1'b1;
          mosi  <= 1'b0;
          cnt   <= '0;
          state <= GAP;
        end

        GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt <= '0;
            if (enable) begin
              state     <= SELECT;
              ss_n[idx] <= 1'b0;
              mosi      <= READ_CMD[15];
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          ss_n   <= '1;
          sck    <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/angle_spi_sampler.md
Name: angle_spi_sampler

Overview:
- Upstream sensor stage for the platform motor controllers: SPI master that polls N magnetic angle sensors (A1339-class) round-robin over a shared SCK/MOSI/MISO bus with per-sensor chip selects.
- Each frame yields a 12-bit angle per sensor plus a one-cycle update strobe. The strobe paces the downstream velocity/PD/PWM update.

Parameters:
- NUMBER_OF_SENSORS, 6: number of sensors and chip selects, 1..16.
- CLOCK_SPEED_HZ, 50_000_000: system clock frequency.
- SCK_HZ, 1_000_000: SPI clock. HALF = CLOCK_SPEED_HZ/(2*SCK_HZ), integer, must be >=2.
- GAP_CYCLES, 50: minimum clocks with all ss_n high between frames.
- READ_CMD, 16'h2000: command word shifted out on every frame (angle register read).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; while high, frames run continuously.
- clear_errors  in  1  one-cycle pulse; clears all error_o bits.
- miso  in  1  shared sensor data out.
- mosi  out  1  command data.
- sck  out  1  SPI clock, idle high.
- ss_n  out  NUMBER_OF_SENSORS  active-low chip selects.
- angle_o  out  12*NUMBER_OF_SENSORS  flattened angles; sensor i occupies [12i+11:12i].
- angle_valid_o  out  NUMBER_OF_SENSORS  one-cycle pulse per accepted sample.
- error_o  out  NUMBER_OF_SENSORS  sticky sensor error flags.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: ss_n all 1, sck=1, mosi=0, angle_o=0, angle_valid_o=0, error_o=0, busy_o=0. FSM goes to IDLE, sensor index=0, all first_frame flags set.
- SPI format:
  - Mode 3 (CPOL=1, CPHA=1), 16-bit frames, MSB first.
  - mosi updates on each sck falling edge. miso is sampled on the clock where sck rises.
  - sck half-period is HALF clocks.
- FSM states:
  - IDLE: all ss_n high. If enable is high, go to SELECT with the current index.
  - SELECT: ss_n[idx]=0, mosi=READ_CMD[15]. Hold HALF clocks, then go to SHIFT.
  - SHIFT: 16 sck low/high periods. The bit counter counts 15 down to 0. The 16th rising-edge sample goes to DESELECT.
  - DESELECT: sck=1, ss_n[idx] held low for HALF clocks, then ss_n[idx]=1 and go to RESULT.
  - RESULT: exactly 1 clock; evaluate the frame (rules below). idx wraps from N-1 to 0. Go to GAP.
  - GAP: GAP_CYCLES clocks with all ss_n high. Then go to SELECT if enable is high, otherwise IDLE.
- Frame evaluation in RESULT, rx = 16 received bits:
  - If first_frame[idx] is set: clear it, discard the data, no strobe (the sensor returns the previous command's response).
  - Else if rx[15]=1 (sensor error): set error_o[idx], angle held, no strobe.
  - Else: angle_o[idx] <= rx[11:0] and angle_valid_o[idx]=1 in the same clock. angle_o is visible the clock after RESULT, coincident with the strobe's registered output.
- At most one ss_n is low at any time. A sensor is never reselected before GAP completes.
- Frame length, SELECT to RESULT: HALF + 32*HALF + HALF + 1 clocks.
- enable falling mid-frame: the current frame completes, including RESULT and GAP, then IDLE. enable rising again: resume at the next idx; first_frame flags are not re-armed.
- clear_errors and a new error on the same clock: set wins, bit stays 1.
- Asynchronous reset mid-frame: all outputs go to reset values immediately. The partial frame is dropped and first_frame flags are re-armed.
- Only the current frame's state is stored. No buffering across frames.

Optional Feature:
- Macro ANGLE_SPI_PARITY_CHECK_EN.
- When defined: rx[12] is an odd-parity bit over rx[15:0]. A frame with even parity is treated like rx[15]=1: error_o[idx] set, angle held, no strobe. A 16-bit parity_fail_count_o output is added, which increments per failed frame, saturates at 16'hFFFF, and resets to 0.
- When undefined: rx[12] is ignored, and the output port and its logic are absent.

Test Plan:
Bench settings for all scenarios: N=2, CLOCK 50 MHz, SCK_HZ 5 MHz (HALF=5), GAP_CYCLES 10.
1. Basic read. Stimulus: enable=1; sensor0 model returns 16'h0ABC. Response: mosi carries 16'h2000; 16 sck rising edges with 10-clock period; first frame gives no strobe; second sensor0 frame gives angle_o[11:0]=12'hABC and one-cycle angle_valid_o[0].
2. Round robin. Stimulus: sensor1 returns 16'h0123. Response: strobes alternate 0,1,0,1; angle_o[23:12]=12'h123; ss_n never 2'b00; at least 10 clocks of ss_n=2'b11 between frames.
3. Error flag. Stimulus: sensor0 returns 16'h8555 after a valid 16'h0ABC. Response: angle held at 12'hABC, error_o[0]=1, no strobe. Then clear_errors on the same clock as another error frame's RESULT: error_o[0] stays 1. A later lone clear: error_o[0]=0.
4. Enable drop. Stimulus: deassert enable at bit 7 of a frame. Response: frame completes with strobe, GAP runs, then IDLE with ss_n=2'b11, sck=1, busy_o=0.
5. Reset mid-frame. Stimulus: assert reset at bit 5. Response: outputs immediately at reset values. After release, the first frame of each sensor gives no strobe.
6. Parity (with ANGLE_SPI_PARITY_CHECK_EN defined). Stimulus: sensor returns 16'h0ABC with a flipped parity bit. Response: error_o set, parity_fail_count_o=1, angle unchanged.
